// File: rtl/alex_word_builder.sv
// ---------------------------------------------------------------------------
// alex_word_builder
//
// Builds the 32-bit Alex relay control word from the tuned frequency and a
// handful of front-end controls. A frequency strobe triggers a serial band
// scan, one threshold compare per cycle: first the HPF table, then the LPF
// table. The scan results are then merged with the control fields into
// Alex_data. A control-only change skips the scan and reuses the last band
// selection. Every word write is followed by a hold-off of HOLDOFF_CYCLES
// cycles. Strobes that arrive while the block is busy are parked in a shadow
// register (last one wins) and are replayed on return to IDLE.
//
// Optional feature: define ALEX_6M_PREAMP_EN to add a sixth HPF compare at
// 50 MHz. Frequencies at or above 50 MHz then select HPF bit 6 (6 m preamp).
// Without it, HPF bit 6 is always 0.
//
// Ports:
//   clock       in   1  sole clock
//   reset_n     in   1  asynchronous active-low reset
//   freq_hz     in  32  tuned frequency, unsigned Hz
//   freq_valid  in   1  one-cycle strobe qualifying freq_hz
//   ptt         in   1  transmit request
//   rx_ant      in   2  RX antenna select
//   tx_ant      in   2  TX antenna select
//   atten       in   2  step attenuator code
//   hpf_bypass  in   1  force HPF bypass
//   Alex_data   out 32  assembled relay word (registered)
//   enable      out  1  sticky word-valid (registered)
//   busy        out  1  high in any state except IDLE (registered)
// ---------------------------------------------------------------------------
module alex_word_builder #(
    parameter int unsigned HOLDOFF_CYCLES = 4096
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] freq_hz,
    input  logic        freq_valid,
    input  logic        ptt,
    input  logic [1:0]  rx_ant,
    input  logic [1:0]  tx_ant,
    input  logic [1:0]  atten,
    input  logic        hpf_bypass,
    output logic [31:0] Alex_data,
    output logic        enable,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCAN_HPF = 3'd1,
        SCAN_LPF = 3'd2,
        ASSEMBLE = 3'd3,
        HOLD     = 3'd4
    } state_t;

    // Index of the last HPF compare. A miss on every compare selects the
    // bit one above it.
`ifdef ALEX_6M_PREAMP_EN
    localparam logic [2:0] HPF_LAST = 3'd5;
`else
    localparam logic [2:0] HPF_LAST = 3'd4;
`endif
    localparam logic [2:0]  LPF_LAST  = 3'd5;
    localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF_CYCLES - 1);
    localparam logic [31:0] RESET_WORD = 32'h0000_0081;

    // HPF band edges in Hz, in scan order.
    function automatic logic [31:0] hpf_thr(input logic [2:0] idx);
        case (idx)
            3'd0:    hpf_thr = 32'd1_500_000;
            3'd1:    hpf_thr = 32'd6_500_000;
            3'd2:    hpf_thr = 32'd9_500_000;
            3'd3:    hpf_thr = 32'd13_000_000;
            3'd4:    hpf_thr = 32'd20_000_000;
            default: hpf_thr = 32'd50_000_000;
        endcase
    endfunction

    // LPF band edges in Hz, in scan order.
    function automatic logic [31:0] lpf_thr(input logic [2:0] idx);
        case (idx)
            3'd0:    lpf_thr = 32'd2_000_000;
            3'd1:    lpf_thr = 32'd4_000_000;
            3'd2:    lpf_thr = 32'd7_300_000;
            3'd3:    lpf_thr = 32'd14_350_000;
            3'd4:    lpf_thr = 32'd21_450_000;
            default: lpf_thr = 32'd29_700_000;
        endcase
    endfunction

    state_t      r_state;
    logic [31:0] r_freq;
    logic [31:0] r_shadow;
    logic        r_pending;
    logic [15:0] r_holdoff;
    logic [2:0]  r_idx;
    logic        r_hit;           // an earlier compare in this scan already hit
    logic [2:0]  r_hpf_sel;       // selected HPF bit position
    logic [2:0]  r_lpf_sel;       // selected LPF bit offset from bit 7
    logic        r_bypass_applied;
    logic [31:0] r_alex_data;
    logic        r_enable;
    logic        r_busy;

    logic        w_hpf_lt;
    logic        w_lpf_lt;
    logic        w_ctrl_diff;
    logic [6:0]  w_hpf_onehot;
    logic [6:0]  w_lpf_onehot;

    // Strict less-than: a frequency equal to an edge falls into the upper band.
    assign w_hpf_lt = (r_freq < hpf_thr(r_idx));
    assign w_lpf_lt = (r_freq < lpf_thr(r_idx));

    // The bypass request is not recoverable from the word itself, because
    // bit 0 is also set naturally below 1.5 MHz. The applied value is
    // therefore tracked separately.
    assign w_ctrl_diff = ({ptt, tx_ant, rx_ant, atten} != r_alex_data[20:14]) ||
                         (hpf_bypass != r_bypass_applied);

    assign w_hpf_onehot = hpf_bypass ? 7'b000_0001 : (7'b000_0001 << r_hpf_sel);
    assign w_lpf_onehot = 7'b000_0001 << r_lpf_sel;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, whatever the order of statements in the block.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= IDLE;
            r_freq           <= '0;
            r_shadow         <= '0;
            r_pending        <= 1'b0;
            r_holdoff        <= '0;
            r_idx            <= '0;
            r_hit            <= 1'b0;
            r_hpf_sel        <= '0;
            r_lpf_sel        <= '0;
            r_bypass_applied <= 1'b0;
            r_alex_data      <= RESET_WORD;
            r_enable         <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            // Strobes while busy are parked; the last one wins.
            if (freq_valid && (r_state != IDLE)) begin
                r_shadow  <= freq_hz;
                r_pending <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (freq_valid || r_pending) begin
                        r_freq    <= freq_valid ? freq_hz : r_shadow;
                        r_pending <= 1'b0;
                        r_idx     <= '0;
                        r_hit     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= SCAN_HPF;
                    end else if (w_ctrl_diff) begin
                        r_busy  <= 1'b1;
                        r_state <= ASSEMBLE;
                    end
                end

                SCAN_HPF: begin
                    if (!r_hit && w_hpf_lt) begin
                        r_hpf_sel <= r_idx;
                        r_hit     <= 1'b1;
                    end
                    if (r_idx == HPF_LAST) begin
                        if (!r_hit && !w_hpf_lt)
                            r_hpf_sel <= HPF_LAST + 3'd1;
                        r_idx   <= '0;
                        r_hit   <= 1'b0;
                        r_state <= SCAN_LPF;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end

                SCAN_LPF: begin
                    if (!r_hit && w_lpf_lt) begin
                        r_lpf_sel <= r_idx;
                        r_hit     <= 1'b1;
                    end
                    if (r_idx == LPF_LAST) begin
                        if (!r_hit && !w_lpf_lt)
                            r_lpf_sel <= LPF_LAST + 3'd1;
                        r_idx   <= '0;
                        r_state <= ASSEMBLE;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end

                ASSEMBLE: begin
                    r_alex_data      <= {11'd0, ptt, tx_ant, rx_ant, atten,
                                         w_lpf_onehot, w_hpf_onehot};
                    r_bypass_applied <= hpf_bypass;
                    r_enable         <= 1'b1;
                    r_holdoff        <= HOLD_LOAD;
                    r_state          <= HOLD;
                end

                HOLD: begin
                    if (r_holdoff == 16'd0) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_holdoff <= r_holdoff - 16'd1;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Alex_data = r_alex_data;
    assign enable    = r_enable;
    assign busy      = r_busy;

endmodule

// File: tb/tb_alex_word_builder.sv
// ---------------------------------------------------------------------------
// tb_alex_word_builder
//
// Directed bench for alex_word_builder, with HOLDOFF_CYCLES = 16. Inputs
// change and outputs are sampled 1 ns after a rising edge. Every expected
// word below is worked out by hand from the band tables:
//   HPF edges 1.5/6.5/9.5/13/20 (/50) MHz -> bits 0..4 (5, or 5/6 with 6 m)
//   LPF edges 2.0/4.0/7.3/14.35/21.45/29.7 MHz -> bits 7..12, else 13
// ---------------------------------------------------------------------------
module tb_alex_word_builder;

`ifdef ALEX_6M_PREAMP_EN
    localparam int          SCAN_LAT = 13;
    localparam logic [31:0] W_52M    = 32'h0000_2040;
`else
    localparam int          SCAN_LAT = 12;
    localparam logic [31:0] W_52M    = 32'h0000_2020;
`endif
    localparam int HOLD = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] freq_hz = '0;
    logic        freq_valid = 1'b0;
    logic        ptt = 1'b0;
    logic [1:0]  rx_ant = '0;
    logic [1:0]  tx_ant = '0;
    logic [1:0]  atten = '0;
    logic        hpf_bypass = 1'b0;
    logic [31:0] Alex_data;
    logic        enable;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alex_word_builder #(.HOLDOFF_CYCLES(HOLD)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .freq_hz    (freq_hz),
        .freq_valid (freq_valid),
        .ptt        (ptt),
        .rx_ant     (rx_ant),
        .tx_ant     (tx_ant),
        .atten      (atten),
        .hpf_bypass (hpf_bypass),
        .Alex_data  (Alex_data),
        .enable     (enable),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [31:0] f);
        freq_hz    = f;
        freq_valid = 1'b1;
        tick(1);
        freq_valid = 1'b0;
    endtask

    // Strobe a frequency from IDLE and check the exact update edge.
    task automatic freq_word(input string tag, input logic [31:0] f,
                             input logic [31:0] old_w, input logic [31:0] new_w);
        strobe(f);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        tick(SCAN_LAT - 1);
        check({tag, "_early"}, Alex_data, old_w);
        tick(1);
        check({tag, "_word"}, Alex_data, new_w);
        check({tag, "_en"}, {31'd0, enable}, 32'd1);
    endtask

    // Control-only change: word lands one edge after the detecting edge.
    task automatic ctrl_word(input string tag, input logic [31:0] old_w,
                             input logic [31:0] new_w);
        tick(1);
        check({tag, "_early"}, Alex_data, old_w);
        tick(1);
        check({tag, "_word"}, Alex_data, new_w);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick(1);
            n++;
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // Reset: asserted asynchronously, checked while held and after release.
        #1 reset_n = 1'b0;
        #1;
        check("rst_word", Alex_data, 32'h0000_0081);
        check("rst_en", {31'd0, enable}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        tick(4);
        check("idle_word", Alex_data, 32'h0000_0081);
        check("idle_en", {31'd0, enable}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // 7.1 MHz: HPF bit 2, LPF bit 9. Hold-off length checked exactly.
        freq_word("f7m1", 32'd7_100_000, 32'h0000_0081, 32'h0000_0204);
        tick(HOLD - 1);
        check("hold_busy", {31'd0, busy}, 32'd1);
        tick(1);
        check("hold_end", {31'd0, busy}, 32'd0);
        check("hold_stable", Alex_data, 32'h0000_0204);

        // Control-only updates.
        ptt = 1'b1;
        ctrl_word("ptt_on", 32'h0000_0204, 32'h0010_0204);
        wait_idle("ptt_on");
        ptt = 1'b0;
        ctrl_word("ptt_off", 32'h0010_0204, 32'h0000_0204);
        wait_idle("ptt_off");
        atten = 2'd2; rx_ant = 2'd1; tx_ant = 2'd3;
        ctrl_word("fields", 32'h0000_0204, 32'h000D_8204);
        wait_idle("fields");
        atten = 2'd0; rx_ant = 2'd0; tx_ant = 2'd0;
        hpf_bypass = 1'b1;
        ctrl_word("bypass_on", 32'h000D_8204, 32'h0000_0201);
        wait_idle("bypass_on");
        hpf_bypass = 1'b0;
        ctrl_word("bypass_off", 32'h0000_0201, 32'h0000_0204);
        wait_idle("bypass_off");
        tick(5);
        check("no_spurious", {31'd0, busy}, 32'd0);

        // Band edges: equal to an edge selects the upper band.
        // 1.5 MHz: HPF bit 1, still below the 2.0 MHz LPF edge (bit 7).
        freq_word("f1m5", 32'd1_500_000, 32'h0000_0204, 32'h0000_0082);
        wait_idle("f1m5");
        freq_word("f52m", 32'd52_000_000, 32'h0000_0082, W_52M);
        wait_idle("f52m");
        freq_word("f1m499", 32'd1_499_999, W_52M, 32'h0000_0081);
        wait_idle("f1m499");
        // 20 MHz exactly: misses the 20 MHz HPF edge (bit 5), LPF bit 11.
        freq_word("f20m", 32'd20_000_000, 32'h0000_0081, 32'h0000_0820);

        // Two strobes during hold-off: only the last (14.2 MHz) is applied.
        strobe(32'd3_600_000);
        strobe(32'd14_200_000);
        wait_idle("pend");
        tick(SCAN_LAT);
        check("pend_early", Alex_data, 32'h0000_0820);
        tick(1);
        check("pend_word", Alex_data, 32'h0000_0410);
        wait_idle("pend2");
        tick(20);
        check("pend_clear_busy", {31'd0, busy}, 32'd0);
        check("pend_clear_word", Alex_data, 32'h0000_0410);

        // Reset during SCAN_LPF with a pending strobe: everything discarded.
        strobe(32'd5_000_000);
        tick(2);
        strobe(32'd9_000_000);
        tick(4);
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #2;
        check("mid_rst_word", Alex_data, 32'h0000_0081);
        check("mid_rst_en", {31'd0, enable}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        #3 reset_n = 1'b1;
        tick(1);
        tick(30);
        check("post_rst_word", Alex_data, 32'h0000_0081);
        check("post_rst_en", {31'd0, enable}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
